// File: rtl/ysyx_041514_pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush and a registered PC redirect.
// Optional YSYX_041514_PIPE_PERF_EN adds 64-bit stall-cycle and redirect counters.
module ysyx_041514_pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_busy_i,
  input  logic        load_use_i,
  input  logic        ex_busy_i,
  input  logic        mem_busy_i,
  input  logic        bru_redirect_i,
  input  logic [63:0] bru_pc_i,
  input  logic        trap_valid_i,
  input  logic [63:0] trap_pc_i,
  output logic [5:0]  stall_valid_o,
  output logic [5:0]  flush_valid_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic [63:0] stall_cnt_o,
  output logic [63:0] flush_cnt_o
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, ISSUE} state_t;

  state_t      state_reg, state_next;
  logic [63:0] redirect_pc_reg, redirect_pc_next;
  logic        redirect_valid_reg;
  logic        trap_acc, bru_acc;
  logic [5:0]  stall_raw, flush_raw;

  // A trap needs a quiet MEM stage; a branch additionally needs EX settled and
  // is only taken while no redirect is already in flight.
  always_comb begin
    trap_acc = trap_valid_i & ~mem_busy_i;
    bru_acc  = bru_redirect_i & ~mem_busy_i & ~ex_busy_i & ~trap_acc & (state_reg == IDLE);
  end

  always_comb begin
    state_next       = state_reg;
    redirect_pc_next = redirect_pc_reg;
    case (state_reg)
      IDLE: begin
        if (trap_acc || bru_acc) begin
          redirect_pc_next = trap_acc ? trap_pc_i : bru_pc_i;
          state_next       = if_busy_i ? WAIT_IF : ISSUE;
        end
      end
      WAIT_IF: begin
        if (trap_acc) redirect_pc_next = trap_pc_i;
        if (!if_busy_i) state_next = ISSUE;
      end
      ISSUE: begin
        if (trap_acc) begin
          redirect_pc_next = trap_pc_i;
          state_next       = if_busy_i ? WAIT_IF : ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_raw = 6'b000000;
    flush_raw = 6'b000000;
    if (mem_busy_i) begin
      stall_raw = 6'b001111;
      flush_raw = 6'b010000;
    end else if (ex_busy_i) begin
      stall_raw = 6'b000111;
      flush_raw = 6'b001000;
    end else if (load_use_i) begin
      stall_raw = 6'b000011;
      flush_raw = 6'b000100;
    end else if (if_busy_i) begin
      stall_raw = 6'b000001;
      flush_raw = 6'b000010;
    end
    if (state_reg == WAIT_IF) begin
      stall_raw[0] = 1'b1;
      flush_raw[1] = 1'b1;
    end
    if (state_reg == ISSUE) flush_raw[1] = 1'b1;
    // A trap squashes everything younger than MEM; only the PC is held, and
    // only while an earlier redirect is still waiting on fetch.
    if (trap_acc) begin
      flush_raw = flush_raw | 6'b011110;
      stall_raw = {5'b00000, state_reg == WAIT_IF};
    end
    if (bru_acc) flush_raw = flush_raw | 6'b000110;
  end

  assign stall_valid_o    = rst ? (stall_raw & ~flush_raw) : 6'b000000;
  assign flush_valid_o    = rst ? flush_raw : 6'b000000;
  assign redirect_valid_o = redirect_valid_reg;
  assign redirect_pc_o    = redirect_pc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= IDLE;
      redirect_pc_reg    <= 64'd0;
      redirect_valid_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      redirect_pc_reg    <= redirect_pc_next;
      redirect_valid_reg <= (state_next == ISSUE);
    end
  end

`ifdef YSYX_041514_PIPE_PERF_EN
  logic [63:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= 64'd0;
      flush_cnt_reg <= 64'd0;
    end else begin
      if (stall_valid_o[0]) stall_cnt_reg <= stall_cnt_reg + 64'd1;
      if (redirect_valid_reg) flush_cnt_reg <= flush_cnt_reg + 64'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`else
  assign stall_cnt_o = 64'd0;
  assign flush_cnt_o = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_041514_pipe_ctrl.sv
// Scoreboard bench for ysyx_041514_pipe_ctrl: directed hazard scenarios then random traffic.
module tb_ysyx_041514_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_busy_i = 1'b0, load_use_i = 1'b0, ex_busy_i = 1'b0, mem_busy_i = 1'b0;
  logic        bru_redirect_i = 1'b0, trap_valid_i = 1'b0;
  logic [63:0] bru_pc_i = 64'd0, trap_pc_i = 64'd0;
  logic [5:0]  stall_valid_o, flush_valid_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o, stall_cnt_o, flush_cnt_o;

  ysyx_041514_pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .if_busy_i(if_busy_i), .load_use_i(load_use_i), .ex_busy_i(ex_busy_i), .mem_busy_i(mem_busy_i),
    .bru_redirect_i(bru_redirect_i), .bru_pc_i(bru_pc_i),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
    .stall_valid_o(stall_valid_o), .flush_valid_o(flush_valid_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  st;
    logic [5:0]  fl;
    logic        rv;
    logic        in_rst;
    logic [63:0] sc;
    logic [63:0] fc;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] redq[$];
  int          checks = 0;
  int          errors = 0;

  // Reference: a redirect is "owed" once accepted and is emitted the cycle
  // after the first cycle in which fetch is idle.
  bit          m_owed = 0;
  bit          m_issuing = 0;
  logic [63:0] m_pc = 64'd0;
  logic [63:0] m_scnt = 64'd0;
  logic [63:0] m_fcnt = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit ifb, input bit lu, input bit exb, input bit memb,
                     input bit br, input logic [63:0] bpc, input bit tr, input logic [63:0] tpc);
    exp_t        e;
    int          depth;
    bit          trap_ok, br_ok, owed_now;
    logic [63:0] pc_now;
    @(posedge clk);
    #1;
    rst = r; if_busy_i = ifb; load_use_i = lu; ex_busy_i = exb; mem_busy_i = memb;
    bru_redirect_i = br; bru_pc_i = bpc; trap_valid_i = tr; trap_pc_i = tpc;
    if (!r) begin
      e = '{st: 6'd0, fl: 6'd0, rv: 1'b0, in_rst: 1'b1, sc: 64'd0, fc: 64'd0};
      expq.push_back(e);
      m_owed = 0; m_issuing = 0; m_pc = 64'd0; m_scnt = 64'd0; m_fcnt = 64'd0;
      redq.delete();
      return;
    end
    depth = memb ? 4 : exb ? 3 : lu ? 2 : ifb ? 1 : 0;
    e.st = 6'((1 << depth) - 1);
    e.fl = (depth != 0) ? 6'(1 << depth) : 6'd0;
    if (m_owed) begin e.st[0] = 1'b1; e.fl[1] = 1'b1; end
    if (m_issuing) e.fl[1] = 1'b1;
    trap_ok = tr && !memb;
    br_ok   = br && !memb && !exb && !trap_ok && !m_owed && !m_issuing;
    if (trap_ok) begin
      e.fl = e.fl | 6'b011110;
      e.st = m_owed ? 6'd1 : 6'd0;
    end
    if (br_ok) e.fl = e.fl | 6'b000110;
    e.st = e.st & ~e.fl;
    e.rv = m_issuing;
    e.in_rst = 1'b0;
    e.sc = m_scnt;
    e.fc = m_fcnt;
    expq.push_back(e);
    m_scnt = m_scnt + 64'(e.st[0]);
    m_fcnt = m_fcnt + 64'(m_issuing);
    owed_now = m_owed;
    pc_now = m_pc;
    if (trap_ok) begin owed_now = 1; pc_now = tpc; end
    else if (br_ok) begin owed_now = 1; pc_now = bpc; end
    m_issuing = owed_now && !ifb;
    m_owed = owed_now && ifb;
    m_pc = pc_now;
    if (m_issuing) redq.push_back(pc_now);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 64'd0, 0, 64'd0);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [63:0] pc;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall", 64'(stall_valid_o), 64'(e.st));
        chk("flush", 64'(flush_valid_o), 64'(e.fl));
        chk("redirect_valid", 64'(redirect_valid_o), 64'(e.rv));
        if (e.in_rst) chk("reset_pc", redirect_pc_o, 64'd0);
`ifdef YSYX_041514_PIPE_PERF_EN
        chk("stall_cnt", stall_cnt_o, e.sc);
        chk("flush_cnt", flush_cnt_o, e.fc);
`else
        chk("stall_cnt", stall_cnt_o, 64'd0);
        chk("flush_cnt", flush_cnt_o, 64'd0);
`endif
        if (redirect_valid_o === 1'b1) begin
          if (redq.size() == 0) begin
            chk("unexpected_redirect", 64'd1, 64'd0);
          end else begin
            pc = redq.pop_front();
            chk("redirect_pc", redirect_pc_o, pc);
            $display("redirect pc=%h t=%0t", redirect_pc_o, $time);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [63:0] bpc, tpc;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 64'd0, 0, 64'd0);
    idle(2);
    cyc(1, 0, 0, 1, 1, 0, 64'd0, 0, 64'd0);                   // mem+ex busy
    cyc(1, 0, 1, 0, 0, 0, 64'd0, 0, 64'd0);                   // single load-use
    idle(2);
    cyc(1, 1, 0, 0, 0, 1, 64'h8000_0100, 0, 64'd0);           // branch while fetch busy
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 64'd0, 0, 64'd0);
    idle(4);
    cyc(1, 0, 0, 0, 0, 1, 64'h100, 1, 64'h8000_0000);         // trap beats branch
    idle(4);
    cyc(1, 1, 0, 0, 0, 1, 64'h8000_0200, 0, 64'd0);           // reset while waiting
    cyc(1, 1, 0, 0, 0, 0, 64'd0, 0, 64'd0);
    cyc(0, 1, 0, 0, 0, 0, 64'd0, 0, 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 64'd0, 0, 64'd0);
    idle(4);
    for (int n = 0; n < 1500; n++) begin
      bpc = {$urandom, $urandom};
      tpc = {$urandom, $urandom};
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 12),
          ($urandom_range(0, 99) < 20), bpc,
          ($urandom_range(0, 99) < 8), tpc);
    end
    idle(6);
    @(negedge clk);
    #1;
    chk("redirect_queue_drained", 64'(redq.size()), 64'd0);
    chk("expect_queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
